// File: rtl/uart_rx_deserializer.sv
// UART Rx deserializer: confirms the start bit at mid-bit, samples W data bits LSB-first, checks parity/stop and holds the word until rx_ack.
// Output loads on the stop-sample edge; an un-acked word is overwritten with overrun_error. Parity bit built only when UART_RX_PARITY_EN is defined.
module uart_rx_deserializer #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int CLOCKS_PER_BIT =
`ifdef FORMAL
        8
`else
        5000
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        serial_in_synced,
    input  logic                        start_detected,
    input  logic                        rx_ack,
    output logic [INPUT_DATA_WIDTH-1:0] rx_data,
    output logic                        rx_valid,
    output logic                        parity_error,
    output logic                        framing_error,
    output logic                        overrun_error,
    output logic                        busy
);
    localparam int W  = INPUT_DATA_WIDTH;
    localparam int C  = CLOCKS_PER_BIT;
    localparam int H  = C / 2;
    localparam int TW = $clog2(C);
    localparam int BW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic            armed_q, armed_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [W-1:0]    data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            oerr_q, oerr_d;
    logic            half_tick, bit_tick;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
            tmr_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        armed_d   = 1'b0;
        tmr_d     = tmr_q + TW'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = ferr_q;
        oerr_d    = oerr_q;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = perr_q;
`endif
        half_tick = (tmr_q == TW'(H - 1));
        bit_tick  = (tmr_q == TW'(C - 1));

        // Ack is applied first so a load on the same edge takes precedence.
        if (valid_q && rx_ack) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            oerr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d  = 1'b0;
`endif
        end

        case (state_q)
            S_IDLE: begin
                tmr_d   = '0;
                bit_d   = '0;
                armed_d = armed_q | serial_in_synced;
                if (armed_q && start_detected && !serial_in_synced) begin
                    state_d = S_START;
                    armed_d = 1'b0;
                end
            end
            S_START: begin
                if (half_tick) begin
                    tmr_d   = '0;
                    state_d = serial_in_synced ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    tmr_d   = '0;
                    shift_d = {serial_in_synced, shift_q[W-1:1]};
                    if (bit_q == BW'(W - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_tick) begin
                    tmr_d   = '0;
                    par_d   = serial_in_synced ^ (^shift_q);
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_tick) begin
                    tmr_d   = '0;
                    state_d = S_IDLE;
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    ferr_d  = !serial_in_synced;
                    oerr_d  = valid_q && !rx_ack;
`ifdef UART_RX_PARITY_EN
                    perr_d  = par_q;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign framing_error = ferr_q;
    assign overrun_error = oerr_q;
    assign busy          = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_error  = perr_q;
`else
    assign parity_error  = 1'b0;
`endif

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Receive-path stage directly downstream of the start-bit detector in the UART Rx chain. It consumes the synchronized serial line and the detector's `start_detected` flag, confirms the start bit at mid-bit, samples data bits LSB-first, checks parity and stop bit, and presents the received word with a valid/ack handshake to the consuming logic. It reports parity, framing and overrun errors alongside the data.

## Interface
- `INPUT_DATA_WIDTH`, 8, data bits per frame (W).
- `CLOCKS_PER_BIT`, 5000 (8 under `FORMAL`), system clocks per UART bit (C); must be even and ≥ 4.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `serial_in_synced`  in  1  line already synchronized to `clk`; idle high.
- `start_detected`  in  1  level flag from the start-bit detector.
- `rx_ack`  in  1  consumer accepts the held word.
- `rx_data`  out  W  received word, bit 0 is the first data bit on the line.
- `rx_valid`  out  1  `rx_data` and error flags are valid; held until acked.
- `parity_error`  out  1  parity mismatch on the held word.
- `framing_error`  out  1  stop bit sampled low on the held word.
- `overrun_error`  out  1  a newer frame overwrote an un-acked word.
- `busy`  out  1  frame reception in progress (state ≠ IDLE).

## Operation
- Reset value of every output: 0. State IDLE, `armed` = 0, counters 0. Reset mid-frame abandons the frame with no flags.
- `armed` sets on any IDLE cycle with `serial_in_synced` = 1; it clears on leaving IDLE. A held-low line (break) therefore never restarts reception.
- States and transitions:
  - IDLE -> START when `armed` & `start_detected` & !`serial_in_synced`. The cycle this is sampled is T.
  - START: count C/2 cycles, then sample the line. If high (false start) -> IDLE with no output. If low -> DATA.
  - DATA: sample one bit every C cycles into the shift register, LSB first. After bit W-1 -> PARITY (or STOP when parity is compiled out).
  - PARITY: sample after C cycles; compute `parity_error` = sampled bit XOR (XOR-reduce of data), i.e. even parity.
  - STOP: sample after C cycles; `framing_error` = !sample. Load outputs -> IDLE.
- Bit-timer width is `$clog2(CLOCKS_PER_BIT)`. It resets to 0 on every sample and never wraps past C-1.
- A frame with errors is still delivered; its flags accompany it.
- Handshake:
  - `rx_valid` rises on the load edge and stays high until `rx_ack` is sampled high with `rx_valid` = 1.
  - `rx_ack` with `rx_valid` = 0 is ignored.
  - `rx_data` and flags are stable while `rx_valid` = 1.
  - The ack clears `rx_valid` and all three error flags.
- Simultaneous events:
  - Load with `rx_valid` = 1 and no ack: overwrite data and flags, set `overrun_error`, keep `rx_valid` = 1.
  - Load and ack on the same edge: the new word loads, `rx_valid` stays 1, `overrun_error` = 0.

## Timing
- H = C/2, P = 1 if parity is compiled in, else 0.
- Sample instants (posedges): start T+H; data bit i at T+H+(i+1)·C; parity at T+H+(W+1)·C; stop at S = T+H+(W+1+P)·C.
- Outputs load on edge S and are visible after it, which is one cycle of latency from the stop sample.
- `busy` is high from the edge after T through edge S inclusive. It is low on the cycle `rx_valid` first appears.
- The earliest next start trigger is the first IDLE cycle after S with `armed` set.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is start + W data + parity + stop (W+3 bits).
  - The PARITY state exists and `parity_error` is driven as above.
- `UART_RX_PARITY_EN` undefined:
  - Frame is start + W data + stop.
  - The PARITY state and parity logic are not built; DATA goes straight to STOP.
  - `parity_error` is tied to 0, and S = T+H+(W+1)·C.

## Test plan
- Clean frame, parity on, C=8, W=8, byte 0xA5 with parity 0 and stop 1; trigger at T -> samples at T+4, T+12…T+68, T+76, T+84. `rx_data`=0xA5 and `rx_valid`=1 after T+84, all flags 0. Ack clears `rx_valid` on the next edge.
- Parity bit 1 on 0xA5 -> `parity_error`=1, `rx_data`=0xA5, `rx_valid`=1. Stop bit 0 on the same frame -> `framing_error`=1.
- False start: line returns high at T+2 -> at T+4 state is IDLE, `busy`=0, no `rx_valid`. Line held low after a framing error -> no new frame until the line is high for at least one cycle.
- Overrun: 0x11 unacked, then 0x22 completes -> `rx_data`=0x22, `overrun_error`=1. Ack on the 0x22 load edge instead -> `rx_data`=0x22, `overrun_error`=0, `rx_valid`=1.
- Reset asserted at T+40 mid-frame -> all outputs 0, IDLE next cycle. Line still low at deassertion -> no reception until the line goes high.
- `UART_RX_PARITY_EN` undefined, byte 0x3C -> stop sampled at T+76, `rx_valid`=1 after T+76, `parity_error`=0 throughout.
